instr_fetch_unit: RTL and testbench

Producer side of the control unit's decode interface. It holds the PC, fetches 32-bit MIPS32 instruction words from instruction memory over a req/ack handshake, and splits each word into fields: Opcode, funct, shamt, register indices, immediate and jump index. After each issued instruction it computes the next PC from the control unit's Branch/PCSrcJal/PCSrcJr decisions. No branch delay slot.

---
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches MIPS32 words over a req/ack
// handshake, decodes the fields of the issued word and selects the next PC
// from the control unit's redirect decisions. No branch delay slot.
module instr_fetch_unit #(
    parameter int unsigned            ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              PCSrcJal,
    input  logic              PCSrcJr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              instr_valid,
    output logic [5:0]        Opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [25:0]       instr_index,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fault
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] target;
    logic              retire;
    logic              misaligned;

    assign retire     = (state == ISSUE) && !stall;
    assign misaligned = (target[1:0] != 2'b00);

    // Next-PC selection; only consumed when the instruction retires.
    always_comb begin
        target = pc_plus4;
        if (PCSrcJr) begin
            target = jr_target;
        end else if (PCSrcJal) begin
            target = {pc_plus4[ADDR_W-1:ADDR_W-4], ir[25:0], 2'b00};
        end else if (branch_taken) begin
            target = pc_plus4 + {{(ADDR_W-18){ir[15]}}, ir[15:0], 2'b00};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    state_next = misaligned ? HALT : FETCH;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // PC, instruction register, link value and sticky fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            ir       <= '0;
            pc_plus4 <= '0;
            fault    <= 1'b0;
        end else if ((state == FETCH) && imem_ack) begin
            ir       <= imem_rdata;
            pc_plus4 <= pc + ADDR_W'(4);
        end else if (retire) begin
            // A misaligned jr target is never loaded; the PC keeps the
            // faulting instruction's address while halted.
            if (misaligned) begin
                fault <= 1'b1;
            end else begin
                pc <= target;
            end
        end
    end

    assign imem_addr   = pc;
    assign Opcode      = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign shamt       = ir[10:6];
    assign funct       = ir[5:0];
    assign imm         = ir[15:0];
    assign instr_index = ir[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized instruction stream checked against a next-PC reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic        PCSrcJal;
    logic        PCSrcJr;
    logic [31:0] jr_target;
    logic        instr_valid;
    logic [5:0]  Opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] instr_index;
    logic [31:0] pc_plus4;
    logic        fault;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .PCSrcJal     (PCSrcJal),
        .PCSrcJr      (PCSrcJr),
        .jr_target    (jr_target),
        .instr_valid  (instr_valid),
        .Opcode       (Opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .funct        (funct),
        .imm          (imm),
        .instr_index  (instr_index),
        .pc_plus4     (pc_plus4),
        .fault        (fault)
    );

    // Reference next-PC rule computed with plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                               input bit jr, input bit jal, input bit br,
                                               input logic [31:0] jt);
        logic [31:0]        link;
        logic signed [15:0] off16;
        int                 off;
        link  = pc + 32'd4;
        off16 = word[15:0];
        off   = off16;
        if (jr)       return jt;
        else if (jal) return (link & 32'hF000_0000) | (32'(word[25:0]) * 32'd4);
        else if (br)  return link + 32'(off * 4);
        else          return link;
    endfunction

    task automatic randomize_redirects();
        branch_taken = 1'($urandom);
        PCSrcJal     = 1'($urandom);
        PCSrcJr      = 1'($urandom);
        jr_target    = $urandom;
    endtask

    // One full fetch/issue/retire transaction; called and returns at a negedge.
    task automatic run_instr(input logic [31:0] word, input int lat, input int nstall,
                             input bit jr, input bit jal, input bit br, input logic [31:0] jt);
        int          n;
        logic [31:0] nxt;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(posedge clk); @(negedge clk); n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
            return;
        end
        checks++;
        if (imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL fetch_addr: got %h required %h", imem_addr, exp_pc);
        end
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL addr_hold: req=%b addr=%h valid=%b required 1 %h 0",
                             imem_req, imem_addr, instr_valid, exp_pc);
                end
            end
            imem_ack   = (k == lat);
            imem_rdata = (k == lat) ? word : $urandom;
            @(posedge clk); @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL issue_flags: valid=%b req=%b required 1 0", instr_valid, imem_req);
        end
        checks++;
        if (Opcode !== word[31:26]) begin
            errors++;
            $display("FAIL opcode: got %b required %b", Opcode, word[31:26]);
        end
        checks++;
        if ({rs, rt, rd, shamt, funct} !== word[25:0]) begin
            errors++;
            $display("FAIL rtype_fields: got %h required %h", {rs, rt, rd, shamt, funct}, word[25:0]);
        end
        checks++;
        if (imm !== word[15:0] || instr_index !== word[25:0]) begin
            errors++;
            $display("FAIL imm_index: got %h %h required %h %h", imm, instr_index, word[15:0], word[25:0]);
        end
        checks++;
        if (pc_plus4 !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL pc_plus4: got %h required %h", pc_plus4, exp_pc + 32'd4);
        end
        for (int s = 0; s < nstall; s++) begin
            stall = 1'b1;
            randomize_redirects();
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            @(posedge clk); @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 ||
                {Opcode, rs, rt, rd, shamt, funct} !== word || pc_plus4 !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL stall_hold: valid=%b req=%b word=%h p4=%h required 1 0 %h %h",
                         instr_valid, imem_req, {Opcode, rs, rt, rd, shamt, funct}, pc_plus4,
                         word, exp_pc + 32'd4);
            end
        end
        stall        = 1'b0;
        imem_ack     = 1'b0;
        PCSrcJr      = jr;
        PCSrcJal     = jal;
        branch_taken = br;
        jr_target    = jt;
        nxt = model_next(exp_pc, word, jr, jal, br, jt);
        @(posedge clk); @(negedge clk);
        randomize_redirects();
        if (nxt[1:0] != 2'b00) begin
            checks++;
            if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_entry: fault=%b req=%b valid=%b required 1 0 0",
                         fault, imem_req, instr_valid);
            end
        end else begin
            checks++;
            if (instr_valid !== 1'b0 || imem_req !== 1'b1 || fault !== 1'b0) begin
                errors++;
                $display("FAIL retire_flags: valid=%b req=%b fault=%b required 0 1 0",
                         instr_valid, imem_req, fault);
            end
            exp_pc = nxt;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, fault} !== 3'b000 || {Opcode, rs, rt, rd, shamt, funct} !== 32'h0 ||
            pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: req/valid/fault=%b ir=%h p4=%h required 000 0 0",
                     {imem_req, instr_valid, fault}, {Opcode, rs, rt, rd, shamt, funct}, pc_plus4);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_idle: req=%b valid=%b required 0 0", imem_req, instr_valid);
        end
        @(posedge clk); @(negedge clk);
        exp_pc = RESET_PC;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_fetch: req=%b addr=%h required 1 %h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential_stall();
        run_instr(32'h8C22_0004, 1, 0, 0, 0, 0, 32'h0);    // lw at 0 -> 4
        run_instr(32'h0123_4567, 0, 1, 0, 0, 0, 32'h0);    // -> 8
        run_instr(32'h0000_0020, 0, 3, 0, 0, 0, 32'h0);    // add at 8, stalled -> 12
        run_instr(32'h2002_0001, 2, 0, 0, 0, 0, 32'h0);    // -> 0x10
    endtask

    task automatic test_branch();
        run_instr(32'h1022_FFFC, 0, 0, 0, 0, 1, 32'h0);    // taken at 0x10 -> 0x04
        run_instr(32'h0000_0000, 1, 0, 1, 0, 0, 32'h10);   // jr back to 0x10
        run_instr(32'h1022_FFFC, 0, 1, 0, 0, 0, 32'h0);    // not taken -> 0x14
    endtask

    task automatic test_jal_jr();
        run_instr(32'h0000_0008, 0, 0, 1, 0, 0, 32'h20);   // jr -> 0x20
        run_instr(32'h0C00_0040, 1, 0, 0, 1, 0, 32'h0);    // jal -> 0x100
        run_instr(32'h0C00_0040, 0, 2, 1, 1, 1, 32'h200);  // jr wins -> 0x200
        run_instr(32'h03E0_0008, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
        run_instr(32'h1000_0001, 1, 0, 0, 0, 0, 32'h0);    // pc_plus4 wraps to 0
        checks++;
        if (exp_pc !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap: addr=%h required 0", imem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] word;
        for (int i = 0; i < 40; i++) begin
            word = $urandom;
            run_instr(word, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                      $urandom & 32'hFFFF_FFFC);
        end
    endtask

    task automatic test_fault();
        run_instr(32'h0040_0008, 0, 0, 1, 0, 0, 32'h202);
        for (int c = 0; c < 4; c++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            @(posedge clk); @(negedge clk);
            checks++;
            if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
                {Opcode, rs, rt, rd, shamt, funct} !== 32'h0040_0008) begin
                errors++;
                $display("FAIL halt_hold: fault=%b req=%b valid=%b ir=%h required 1 0 0 00400008",
                         fault, imem_req, instr_valid, {Opcode, rs, rt, rd, shamt, funct});
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        test_reset();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n      = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, fault} !== 3'b000 || {Opcode, rs, rt, rd, shamt, funct} !== 32'h0 ||
            pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_fetch: req/valid/fault=%b ir=%h p4=%h required 000 0 0",
                     {imem_req, instr_valid, fault}, {Opcode, rs, rt, rd, shamt, funct}, pc_plus4);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || {Opcode, rs, rt, rd, shamt, funct} !== 32'h0) begin
            errors++;
            $display("FAIL stale_ack: req=%b valid=%b ir=%h required 0 0 0",
                     imem_req, instr_valid, {Opcode, rs, rt, rd, shamt, funct});
        end
        imem_ack = 1'b0;
        exp_pc   = RESET_PC;
        run_instr(32'h2408_0005, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        PCSrcJal     = 1'b0;
        PCSrcJr      = 1'b0;
        jr_target    = '0;
        exp_pc       = RESET_PC;
        test_reset();
        test_sequential_stall();
        test_branch();
        test_jal_jr();
        test_random();
        test_fault();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
